// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR random-draw engine.
// Tap masks select the bits XOR-ed into the MSB of a right-shifting
// Fibonacci register; each one gives a maximal-length sequence.
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [5:0]  TAPS_W6  = 6'h03;          // x^6+x^5+1
    localparam logic [7:0]  TAPS_W8  = 8'h1D;          // x^8+x^6+x^5+x^4+1
    localparam logic [15:0] TAPS_W16 = 16'h002D;       // x^16+x^14+x^13+x^11+1
    localparam logic [31:0] TAPS_W32 = 32'hC000_0401;  // x^32+x^22+x^2+x+1

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR shift register with seed load, zero-seed substitution
// and a one-cycle seed_zero flag.
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset (register -> SEED)
//   step_i       shift once this edge
//   load_i       load seed_i this edge (wins over step_i)
//   seed_i       seed value; zero is replaced by SEED
//   draw_nxt_o   low OUT_W bits of the value the register takes next edge
//   seed_zero_o  high for one cycle after a zero seed was replaced
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter int unsigned      OUT_W = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_W16),
    parameter logic [WIDTH-1:0] SEED  = '1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             step_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [OUT_W-1:0] draw_nxt_o,
    output logic             seed_zero_o
);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic             seed_zero_q, seed_zero_d;
    logic             fb;

    // Next register value: load beats step; a zero seed would lock the LFSR.
    always_comb begin
        shift_d     = shift_q;
        seed_zero_d = 1'b0;
        fb          = ^(shift_q & TAPS);
        if (load_i) begin
            if (seed_i == '0) begin
                shift_d     = SEED;
                seed_zero_d = 1'b1;
            end else begin
                shift_d = seed_i;
            end
        end else if (step_i) begin
            shift_d = {fb, shift_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shift_q     <= SEED;
            seed_zero_q <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            seed_zero_q <= seed_zero_d;
        end
    end

    assign draw_nxt_o  = shift_d[OUT_W-1:0];
    assign seed_zero_o = seed_zero_q;

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random-draw engine: a request spins the LFSR STEPS times, then the
// low OUT_W bits are held on q until the consumer takes them.
// Ports:
//   clk_fpga   clock, rising edge
//   reset      synchronous active-high reset
//   seed_load  load seed_in this cycle; aborts any draw in progress
//   seed_in    seed value (zero replaced by SEED)
//   req        draw request, honoured only in IDLE
//   out_valid  q holds a completed draw
//   out_ready  consumer accepts q when out_valid && out_ready
//   q          drawn value, stable while out_valid
//   busy       a draw is spinning or waiting to be taken
//   seed_zero  one-cycle pulse after a zero seed was replaced
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(TAPS_W16),
    parameter logic [WIDTH-1:0] SEED     = '1,
    parameter int unsigned      OUT_W    = 4,
    parameter int unsigned      STEPS    = 4,
    parameter bit               FREE_RUN = 1'b1
) (
    input  logic             clk_fpga,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] q,
    output logic             busy,
    output logic             seed_zero
);

    localparam int unsigned CNT_W = $clog2(STEPS + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] q_q, q_d;
    logic             valid_q, valid_d;
    logic             busy_q;
    logic             step_c;
    logic [OUT_W-1:0] draw_nxt;

    // Kept out of the FSM block: draw_nxt depends on it.
    assign step_c = !seed_load &&
                    ((state_q == SPIN) || ((state_q == IDLE) && FREE_RUN));

    lfsr_core #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk_i       (clk_fpga),
        .reset_i     (reset),
        .step_i      (step_c),
        .load_i      (seed_load),
        .seed_i      (seed_in),
        .draw_nxt_o  (draw_nxt),
        .seed_zero_o (seed_zero)
    );

    // Draw sequencing; a seed load abandons the draw but leaves q untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = valid_q;
        if (seed_load) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_d = SPIN;
                        cnt_d   = CNT_W'(STEPS - 1);
                    end
                end
                SPIN: begin
                    if (cnt_q == '0) begin
                        // Capture the value produced by this final step.
                        q_d     = draw_nxt;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign out_valid = valid_q;
    assign q         = q_q;
    assign busy      = busy_q;

endmodule
